// File: rtl/core_pkg.sv
// Shared fetch definitions: state encoding, NOP word,
// default reset PC and datapath widths.
package core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } fetch_state_e;
endpackage

// File: rtl/core_fetch_skid.sv
// One-entry skid buffer for a response that arrives under stall.
// Ports: LOAD_I/DRAIN_I/FLUSH_I control; INSTR_I/PC_I in; VALID_O/INSTR_O/PC_O out.
module core_fetch_skid
  import core_pkg::*;
(
  input  logic            CLK,
  input  logic            NRST,
  input  logic            LOAD_I,
  input  logic            DRAIN_I,
  input  logic            FLUSH_I,
  input  logic [ILEN-1:0] INSTR_I,
  input  logic [XLEN-1:0] PC_I,
  output logic            VALID_O,
  output logic [ILEN-1:0] INSTR_O,
  output logic [XLEN-1:0] PC_O
);
  logic            valid_q;
  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else if (FLUSH_I) begin
      valid_q <= 1'b0;
    end else if (LOAD_I) begin
      valid_q <= 1'b1;
      instr_q <= INSTR_I;
      pc_q    <= PC_I;
    end else if (DRAIN_I) begin
      valid_q <= 1'b0;
    end
  end

  assign VALID_O = valid_q;
  assign INSTR_O = instr_q;
  assign PC_O    = pc_q;
endmodule

// File: rtl/pc_adder.sv
// PC update adder, shared by sequential fetch.
// Ports: ARG_I1, ARG_I2 operands; RES_O wrapped sum.
module pc_adder
  import core_pkg::*;
(
  input  logic [XLEN-1:0] ARG_I1,
  input  logic [XLEN-1:0] ARG_I2,
  output logic [XLEN-1:0] RES_O
);
  assign RES_O = ARG_I1 + ARG_I2;
endmodule

// File: rtl/core_fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, drives imem req/gnt/rvalid, fills IF/ID.
// Ports: CLK/NRST, STALL, REDIRECT(+PC), IMEM_*, IFID_*; MISALIGN* with FETCH_MISALIGN_CHECK_EN.
module core_fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_INC   = 32'd4
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_GNT,
  input  logic            IMEM_RVALID,
  input  logic [ILEN-1:0] IMEM_RDATA,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            MISALIGN,
  output logic [XLEN-1:0] MISALIGN_ADDR,
`endif
  output logic            IFID_VALID,
  output logic [ILEN-1:0] IFID_INSTR,
  output logic [XLEN-1:0] IFID_PC
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic            ifid_v_q, ifid_v_d;
  logic [ILEN-1:0] ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;

  logic            gnt_hs, ld_resp, ld_skid, skid_load;
  logic            skid_v;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] pc_seq, tgt;
  logic            stay_wait;

  pc_adder u_inc (
    .ARG_I1 (fetch_pc_q),
    .ARG_I2 (PC_INC),
    .RES_O  (pc_seq)
  );

  core_fetch_skid u_skid (
    .CLK     (CLK),
    .NRST    (NRST),
    .LOAD_I  (skid_load),
    .DRAIN_I (ld_skid),
    .FLUSH_I (REDIRECT),
    .INSTR_I (IMEM_RDATA),
    .PC_I    (req_pc_q),
    .VALID_O (skid_v),
    .INSTR_O (skid_instr),
    .PC_O    (skid_pc)
  );

  assign IMEM_REQ  = (state_q == S_REQ);
  assign IMEM_ADDR = fetch_pc_q;
  assign gnt_hs    = IMEM_REQ & IMEM_GNT;
  assign tgt       = REDIRECT_PC & ~32'h3;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            mis_q, mis_d;
  logic [XLEN-1:0] mis_addr_q, mis_addr_d;
  logic            bad_tgt;
  assign bad_tgt = |REDIRECT_PC[1:0];
`endif

  // A response is still owed after this cycle if a grant
  // happens now or one is pending without RVALID.
  assign stay_wait = gnt_hs
    | ((state_q == S_WAIT) & ~IMEM_RVALID)
    | ((state_q == S_TRAP) & kill_q & ~IMEM_RVALID);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    ifid_v_d     = ifid_v_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ld_resp      = 1'b0;
    ld_skid      = 1'b0;
    skid_load    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_d        = mis_q;
    mis_addr_d   = mis_addr_q;
`endif
    if (gnt_hs) req_pc_d = fetch_pc_q;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (IMEM_GNT) begin
          state_d    = S_WAIT;
          fetch_pc_d = pc_seq;
        end
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!STALL) begin
            ld_resp = 1'b1;
            state_d = S_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!STALL) begin
          ld_skid = skid_v;
          state_d = S_REQ;
        end
      end
      S_TRAP: begin
        if (IMEM_RVALID) kill_d = 1'b0;
      end
      default: state_d = S_BOOT;
    endcase

    if (REDIRECT) begin
      ld_resp   = 1'b0;
      ld_skid   = 1'b0;
      skid_load = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis_d      = bad_tgt;
      mis_addr_d = bad_tgt ? REDIRECT_PC : '0;
      if (bad_tgt) begin
        state_d    = S_TRAP;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_d | stay_wait;
      end else
`endif
      begin
        fetch_pc_d = tgt;
        state_d    = stay_wait ? S_WAIT : S_REQ;
        kill_d     = stay_wait;
      end
    end

    if (ld_resp) begin
      ifid_v_d     = 1'b1;
      ifid_instr_d = IMEM_RDATA;
      ifid_pc_d    = req_pc_q;
    end else if (ld_skid) begin
      ifid_v_d     = 1'b1;
      ifid_instr_d = skid_instr;
      ifid_pc_d    = skid_pc;
    end else if (!STALL || REDIRECT) begin
      ifid_v_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q      <= S_BOOT;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      ifid_v_q     <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      ifid_v_q     <= ifid_v_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign MISALIGN      = mis_q;
  assign MISALIGN_ADDR = mis_addr_q;
`endif

  assign IFID_VALID = ifid_v_q;
  assign IFID_INSTR = ifid_instr_q;
  assign IFID_PC    = ifid_pc_q;
endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Directed table-driven bench for core_fetch_ctrl.
// Set FETCH_MISALIGN_CHECK_EN to exercise the misalign outputs.
module tb_core_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A = 32'hA000_0000;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] RP21 = 32'h0000_0200;
`else
  localparam logic [31:0] RP21 = 32'h0000_0203;
`endif

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        IFID_VALID;
  logic [31:0] IFID_INSTR;
  logic [31:0] IFID_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        MISALIGN;
  logic [31:0] MISALIGN_ADDR;
`endif

  int n_chk = 0;
  int n_fail = 0;

  core_fetch_ctrl dut (
    .CLK         (CLK),
    .NRST        (NRST),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
`ifdef FETCH_MISALIGN_CHECK_EN
    .MISALIGN      (MISALIGN),
    .MISALIGN_ADDR (MISALIGN_ADDR),
`endif
    .IFID_VALID  (IFID_VALID),
    .IFID_INSTR  (IFID_INSTR),
    .IFID_PC     (IFID_PC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        s, r;
    logic [31:0] rp;
    logic        g, rv;
    logic [31:0] rd;
    logic        q;
    logic [31:0] a;
    logic        v;
    logic [31:0] p, in;
  } vec_t;

  vec_t vt[36];

  function automatic vec_t mk(
    logic s, logic r, logic [31:0] rp, logic g, logic rv,
    logic [31:0] rd, logic q, logic [31:0] a, logic v,
    logic [31:0] p, logic [31:0] in);
    vec_t x;
    x.s = s; x.r = r; x.rp = rp; x.g = g; x.rv = rv;
    x.rd = rd; x.q = q; x.a = a; x.v = v; x.p = p; x.in = in;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic q, logic [31:0] a,
                         logic v, logic [31:0] p, logic [31:0] in);
    chk({tag, ".req"}, {31'd0, IMEM_REQ}, {31'd0, q});
    chk({tag, ".addr"}, IMEM_ADDR, a);
    chk({tag, ".valid"}, {31'd0, IFID_VALID}, {31'd0, v});
    if (v) chk({tag, ".pc"}, IFID_PC, p);
    if (v) chk({tag, ".instr"}, IFID_INSTR, in);
  endtask

  task automatic drive(logic s, logic r, logic [31:0] rp,
                       logic g, logic rv, logic [31:0] rd);
    STALL = s; REDIRECT = r; REDIRECT_PC = rp;
    IMEM_GNT = g; IMEM_RVALID = rv; IMEM_RDATA = rd;
  endtask

  initial begin
    vt[0]  = mk(O,O,0,I,O,0,          O,32'h0,O,32'h0,NOP);
    vt[1]  = mk(O,O,0,I,O,0,          I,32'h0,O,32'h0,NOP);
    vt[2]  = mk(O,O,0,O,I,A,          O,32'h4,O,32'h0,NOP);
    vt[3]  = mk(O,O,0,I,O,0,          I,32'h4,I,32'h0,A);
    vt[4]  = mk(O,O,0,O,I,A+4,        O,32'h8,O,32'h0,A);
    vt[5]  = mk(O,O,0,O,O,0,          I,32'h8,I,32'h4,A+4);
    vt[6]  = mk(O,O,0,O,O,0,          I,32'h8,O,32'h4,A+4);
    vt[7]  = mk(O,O,0,O,O,0,          I,32'h8,O,32'h4,A+4);
    vt[8]  = mk(O,O,0,I,O,0,          I,32'h8,O,32'h4,A+4);
    vt[9]  = mk(O,O,0,O,I,A+8,        O,32'hC,O,32'h4,A+4);
    vt[10] = mk(I,O,0,I,O,0,          I,32'hC,I,32'h8,A+8);
    vt[11] = mk(I,O,0,O,I,A+12,       O,32'h10,I,32'h8,A+8);
    vt[12] = mk(I,O,0,O,O,0,          O,32'h10,I,32'h8,A+8);
    vt[13] = mk(O,O,0,O,O,0,          O,32'h10,I,32'h8,A+8);
    vt[14] = mk(O,O,0,I,O,0,          I,32'h10,I,32'hC,A+12);
    vt[15] = mk(O,O,0,O,I,A+16,       O,32'h14,O,32'hC,A+12);
    vt[16] = mk(O,O,0,I,O,0,          I,32'h14,I,32'h10,A+16);
    vt[17] = mk(O,I,32'h100,O,O,0,    O,32'h18,O,32'h10,A+16);
    vt[18] = mk(O,O,0,O,I,A+20,       O,32'h100,O,32'h10,A+16);
    vt[19] = mk(O,O,0,I,O,0,          I,32'h100,O,32'h10,A+16);
    vt[20] = mk(O,O,0,O,I,A+32'h100,  O,32'h104,O,32'h10,A+16);
    vt[21] = mk(I,I,RP21,O,O,0,       I,32'h104,I,32'h100,A+32'h100);
    vt[22] = mk(I,O,0,I,O,0,          I,32'h200,O,32'h100,A+32'h100);
    vt[23] = mk(O,O,0,O,I,A+32'h200,  O,32'h204,O,32'h100,A+32'h100);
    vt[24] = mk(O,I,32'h300,I,O,0,    I,32'h204,I,32'h200,A+32'h200);
    vt[25] = mk(O,O,0,O,I,A+32'h204,  O,32'h300,O,32'h200,A+32'h200);
    vt[26] = mk(O,O,0,I,O,0,          I,32'h300,O,32'h200,A+32'h200);
    vt[27] = mk(O,I,32'h400,O,I,A+32'h300, O,32'h304,O,32'h200,A+32'h200);
    vt[28] = mk(O,O,0,I,O,0,          I,32'h400,O,32'h200,A+32'h200);
    vt[29] = mk(O,O,0,O,I,A+32'h400,  O,32'h404,O,32'h200,A+32'h200);
    vt[30] = mk(O,O,0,I,O,0,          I,32'h404,I,32'h400,A+32'h400);
    vt[31] = mk(O,I,32'hFFFF_FFFC,O,O,0, O,32'h408,O,32'h400,A+32'h400);
    vt[32] = mk(O,O,0,O,I,A+32'h404,  O,32'hFFFF_FFFC,O,32'h400,A+32'h400);
    vt[33] = mk(O,O,0,I,O,0,          I,32'hFFFF_FFFC,O,32'h400,A+32'h400);
    vt[34] = mk(O,O,0,O,I,32'hC0FF_EE00, O,32'h0,O,32'h400,A+32'h400);
    vt[35] = mk(O,O,0,I,O,0,          I,32'h0,I,32'hFFFF_FFFC,32'hC0FF_EE00);

    repeat (2) @(negedge CLK);
    chk("rst.req", {31'd0, IMEM_REQ}, 32'd0);
    chk("rst.addr", IMEM_ADDR, 32'h0);
    chk("rst.valid", {31'd0, IFID_VALID}, 32'd0);
    chk("rst.instr", IFID_INSTR, NOP);
    chk("rst.pc", IFID_PC, 32'h0);
    NRST = 1'b1;

    for (int i = 0; i < 36; i++) begin
      chk_out($sformatf("v%0d", i), vt[i].q, vt[i].a,
              vt[i].v, vt[i].p, vt[i].in);
      drive(vt[i].s, vt[i].r, vt[i].rp, vt[i].g, vt[i].rv, vt[i].rd);
      @(negedge CLK);
    end

    // Reset while a fetch to 0x0 is outstanding.
    drive(O, O, 0, O, O, 0);
    NRST = 1'b0;
    #1;
    chk("mid_rst.req", {31'd0, IMEM_REQ}, 32'd0);
    chk("mid_rst.addr", IMEM_ADDR, 32'h0);
    chk("mid_rst.valid", {31'd0, IFID_VALID}, 32'd0);
    chk("mid_rst.instr", IFID_INSTR, NOP);
    chk("mid_rst.pc", IFID_PC, 32'h0);
    @(negedge CLK);
    NRST = 1'b1;
    drive(O, O, 0, O, I, 32'hDEAD_BEEF);
    chk_out("boot", O, 32'h0, O, 0, 0);
    @(negedge CLK);
    chk_out("late", I, 32'h0, O, 0, 0);
    drive(O, O, 0, I, I, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk_out("refetch", O, 32'h4, O, 0, 0);
    drive(O, O, 0, O, I, 32'hB000_0000);
    @(negedge CLK);
    chk_out("reload", I, 32'h4, I, 32'h0, 32'hB000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis.reset", {31'd0, MISALIGN}, 32'd0);
    drive(O, I, 32'h102, O, O, 0);
    @(negedge CLK);
    drive(O, O, 0, O, O, 0);
    chk("mis.flag", {31'd0, MISALIGN}, 32'd1);
    chk("mis.addr", MISALIGN_ADDR, 32'h102);
    chk("mis.req", {31'd0, IMEM_REQ}, 32'd0);
    chk("mis.valid", {31'd0, IFID_VALID}, 32'd0);
    @(negedge CLK);
    chk("mis.hold", {31'd0, MISALIGN}, 32'd1);
    chk("mis.hold_req", {31'd0, IMEM_REQ}, 32'd0);
    drive(O, I, 32'h200, O, O, 0);
    @(negedge CLK);
    drive(O, O, 0, O, O, 0);
    chk("mis.clear", {31'd0, MISALIGN}, 32'd0);
    chk("mis.req2", {31'd0, IMEM_REQ}, 32'd1);
    chk("mis.addr2", IMEM_ADDR, 32'h200);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
